// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave responder backed by a P_MEM_DEPTH x 32-bit memory
// with byte enables. Only one transaction is in flight at a time.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   s_axi_aw*/s_axi_w*    write address / write data channels
//   s_axi_b*              write response channel
//   s_axi_ar*/s_axi_r*    read address / read data channels
//   lock/cache/prot/qos   accepted and ignored
module axi_slave_mem #(
    parameter int P_ID_WIDTH       = 4,
    parameter int P_MEM_DEPTH      = 1024,
    parameter int P_RD_LATENCY_ADD = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [P_ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [P_ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [P_ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]           s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    output logic [P_ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int IDX_W = $clog2(P_MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA} state_t;
    state_t state_q, state_d;

    logic                  rdy_q;     // holds the address readies low until the first cycle after reset
    logic [P_ID_WIDTH-1:0] id_q;
    logic [IDX_W-1:0]      idx_q;
    logic [7:0]            len_q, cnt_q;
    logic                  fixed_q, err_q;
    logic [3:0]            lat_q;
    logic                  bvalid_q, rvalid_q, rlast_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [P_ID_WIDTH-1:0] bid_q, rid_q;
    logic [31:0]           rdata_q;

    // Storage has no reset; a per-word written flag makes never-written words read as zero.
    logic [31:0]            mem [P_MEM_DEPTH];
    logic [P_MEM_DEPTH-1:0] vld_q;

    logic aw_hs, ar_hs, w_hs, b_hs, r_hs, w_last_beat, w_mismatch, aw_err, ar_err;
    logic [IDX_W-1:0] idx_nxt, rd_idx;
    logic [31:0]      rd_word, wr_word;

    assign s_axi_awready = rdy_q && (state_q == IDLE);
    assign s_axi_arready = rdy_q && (state_q == IDLE) && !s_axi_awvalid;  // write wins a tie
    assign s_axi_wready  = (state_q == WR_DATA);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = bvalid_q && s_axi_bready;
    assign r_hs        = rvalid_q && s_axi_rready;
    assign w_last_beat = (cnt_q == len_q);
    assign w_mismatch  = (s_axi_wlast != w_last_beat);
    assign aw_err      = (s_axi_awburst == 2'b11) || (s_axi_awsize != 3'b010);
    assign ar_err      = (s_axi_arburst == 2'b11) || (s_axi_arsize != 3'b010);
    assign idx_nxt     = fixed_q ? idx_q : idx_q + 1'b1;

    // Address of the word that the next loaded read beat comes from.
    always_comb begin
        rd_idx = idx_nxt;
        if (state_q == IDLE)    rd_idx = s_axi_araddr[IDX_W+1:2];
        if (state_q == RD_WAIT) rd_idx = idx_q;
    end
    assign rd_word = vld_q[rd_idx] ? mem[rd_idx] : 32'h0;

    always_comb begin
        wr_word = 32'h0;
        for (int i = 0; i < 4; i++)
            wr_word[8*i +: 8] = s_axi_wstrb[i] ? s_axi_wdata[8*i +: 8]
                              : (vld_q[idx_q] ? mem[idx_q][8*i +: 8] : 8'h0);
    end

    always_ff @(posedge i_clk) begin
        if (w_hs) mem[idx_q] <= wr_word;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = WR_DATA;
                else if (ar_hs) state_d = (P_RD_LATENCY_ADD == 0) ? RD_DATA : RD_WAIT;
            end
            WR_DATA: if (w_hs && w_last_beat) state_d = WR_RESP;
            WR_RESP: if (b_hs)                state_d = IDLE;
            RD_WAIT: if (lat_q == 4'd1)       state_d = RD_DATA;
            RD_DATA: if (r_hs && rlast_q)     state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_q <= 1'b0;  id_q  <= '0;   idx_q   <= '0;   len_q <= '0;
            cnt_q <= '0;    fixed_q <= 1'b0; err_q <= 1'b0;  lat_q <= '0;
            bvalid_q <= 1'b0; bresp_q <= '0; bid_q <= '0;
            rvalid_q <= 1'b0; rlast_q <= 1'b0; rresp_q <= '0; rid_q <= '0; rdata_q <= '0;
            vld_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        id_q <= s_axi_awid;  idx_q <= s_axi_awaddr[IDX_W+1:2];
                        len_q <= s_axi_awlen; cnt_q <= '0;
                        fixed_q <= (s_axi_awburst == 2'b00); err_q <= aw_err;
                    end else if (ar_hs) begin
                        id_q <= s_axi_arid;  idx_q <= s_axi_araddr[IDX_W+1:2];
                        len_q <= s_axi_arlen; cnt_q <= '0;
                        fixed_q <= (s_axi_arburst == 2'b00); err_q <= ar_err;
                        lat_q <= 4'(P_RD_LATENCY_ADD);
                        if (P_RD_LATENCY_ADD == 0) begin
                            rvalid_q <= 1'b1;  rdata_q <= rd_word;
                            rlast_q  <= (s_axi_arlen == 8'd0);
                            rresp_q  <= ar_err ? 2'b10 : 2'b00;
                            rid_q    <= s_axi_arid;
                        end
                    end
                end
                WR_DATA: if (w_hs) begin
                    vld_q[idx_q] <= 1'b1;
                    if (w_mismatch) err_q <= 1'b1;
                    // Burst length alone ends the write; wlast only affects the response.
                    if (w_last_beat) begin
                        bvalid_q <= 1'b1;
                        bid_q    <= id_q;
                        bresp_q  <= (err_q || w_mismatch) ? 2'b10 : 2'b00;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        idx_q <= idx_nxt;
                    end
                end
                WR_RESP: if (b_hs) bvalid_q <= 1'b0;
                RD_WAIT: begin
                    if (lat_q == 4'd1) begin
                        rvalid_q <= 1'b1;  rdata_q <= rd_word;
                        rlast_q  <= (len_q == 8'd0);
                        rresp_q  <= err_q ? 2'b10 : 2'b00;
                        rid_q    <= id_q;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                RD_DATA: if (r_hs) begin
                    // Beat registers only move on a handshake, so they hold under back-pressure.
                    if (rlast_q) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                        idx_q   <= idx_nxt;
                        rdata_q <= rd_word;
                        rlast_q <= ((cnt_q + 8'd1) == len_q);
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                         s_axi_awaddr[31:IDX_W+2], s_axi_awaddr[1:0],
                         s_axi_araddr[31:IDX_W+2], s_axi_araddr[1:0]};
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter P_ID_WIDTH, default 4: width of AXI ID fields.
REQ-002 SHALL have parameter P_MEM_DEPTH, default 1024: number of 32-bit words; power of two.
REQ-003 SHALL have parameter P_RD_LATENCY_ADD, default 0: extra idle cycles (0..15) inserted before the first read beat.
REQ-004 i_clk  in  1  single clock for all logic.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  P_ID_WIDTH/32/8/3/2/1  write address channel; s_axi_awready  out  1.
REQ-007 s_axi_awlock/awcache/awprot/awqos  in  1/4/3/4  accepted and ignored.
REQ-008 s_axi_wdata/wstrb/wlast/wvalid  in  32/4/1/1  write data channel; s_axi_wready  out  1.
REQ-009 s_axi_bid/bresp/bvalid  out  P_ID_WIDTH/2/1  write response; s_axi_bready  in  1.
REQ-010 s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  P_ID_WIDTH/32/8/3/2/1  read address; s_axi_arready  out  1; arlock/arcache/arprot/arqos  in  ignored.
REQ-011 s_axi_rid/rdata/rresp/rlast/rvalid  out  P_ID_WIDTH/32/2/1/1  read data; s_axi_rready  in  1.

Function
REQ-012 SHALL implement an AXI4 slave responder backed by internal memory of P_MEM_DEPTH x 32 bits with per-byte write enables.
REQ-013 Word index SHALL be addr[log2(P_MEM_DEPTH)+1:2]; upper address bits ignored; index wraps modulo P_MEM_DEPTH.
REQ-014 FSM states: IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA; one transaction outstanding at a time.
REQ-015 IDLE: awready=1 and arready=1; on simultaneous awvalid and arvalid, write SHALL win (only awready asserted that cycle); AW handshake -> WR_DATA; AR handshake -> RD_WAIT (or RD_DATA directly when P_RD_LATENCY_ADD=0).
REQ-016 On AW/AR handshake SHALL latch id, start index, len, burst; awready/arready SHALL be 0 outside IDLE.
REQ-017 Burst FIXED (2'b00): index constant; INCR (2'b01): index+1 per beat; WRAP (2'b10) treated as INCR; 2'b11: processed as INCR, response SLVERR.
REQ-018 awsize/arsize other than 3'b010: processed as 4-byte beats, response SLVERR.
REQ-019 WR_DATA: wready=1; each W handshake writes bytes where wstrb[i]=1; beat counter counts 0..len.
REQ-020 Write burst SHALL end at beat len regardless of wlast; wlast mismatch (early or missing) SHALL set bresp SLVERR; early wlast beats after it still consumed until len reached.
REQ-021 WR_RESP: bvalid asserted the cycle after the final W handshake, bid=latched id, held stable until bready; then IDLE.
REQ-022 Read: first rvalid SHALL appear 1+P_RD_LATENCY_ADD cycles after AR handshake; then one beat per cycle while rready=1.
REQ-023 rdata/rid/rresp/rlast SHALL hold stable while rvalid=1 and rready=0; no beat lost or duplicated under back-pressure.
REQ-024 rlast=1 only on beat len; after its handshake -> IDLE, arready/awready reasserted the next cycle.
REQ-025 Read of locations never written SHALL return 32'h0 (memory zero-initialised); read-after-write of same address SHALL return the written data.
REQ-026 bresp/rresp OKAY (2'b00) unless REQ-017/018/020 give SLVERR (2'b10); rresp constant over a burst.

Reset
REQ-027 i_rst_n low SHALL asynchronously force: FSM IDLE, awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0; awready/arready rise the first cycle after deassert.
REQ-028 Reset mid-burst SHALL abort the transaction without response; memory contents need not be cleared.

Verification
REQ-029 Single write awaddr=0x10,len=0,wdata=0xDEADBEEF,wstrb=4'hF, then read 0x10 len=0 -> bresp=0, rdata=0xDEADBEEF, rlast=1, rid=arid.
REQ-030 INCR write len=255 data=beat index from 0x0, then read len=255 with rready toggling every other cycle -> 256 beats 0..255 in order, rlast only on beat 255.
REQ-031 Write 0x20 0xFFFFFFFF, then 0x20 wdata=0x00000000 wstrb=4'b0101 -> read returns 0xFF00FF00.
REQ-032 awvalid and arvalid asserted same cycle in IDLE -> write completes (bvalid) before first rvalid; read returns new data.
REQ-033 Write len=3 with wlast on beat 1 -> four beats accepted, bresp=2'b10; arburst=2'b11 read -> rresp=2'b10 all beats.
REQ-034 Assert i_rst_n=0 during beat 5 of a len=15 read -> rvalid=0 immediately; after release a new len=0 read completes normally.
